// File: rtl/mem_wb_pkg.sv
// Shared types and constants for the MEM stage and its MEM/WB latch.
package mem_wb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int MEM_LATENCY_MAX = 4;
  localparam int WB_DST_W        = 5;
  localparam int CNT_W           = $clog2(MEM_LATENCY_MAX);

endpackage

// File: rtl/data_ram.sv
// Single-port data memory: 2^ADDR_W x 32, asynchronous read, synchronous write.
module data_ram #(
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [31:0]       i_wdata,
  output logic [31:0]       o_rdata
);

  logic [31:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage: branch resolution, multi-cycle data-memory access, MEM/WB latch.
// Optional macro MEM_ALIGN_CHECK_EN adds a sticky addr_err output for misaligned accesses.
module mem_wb_stage
  import mem_wb_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int MEM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        branch_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic [6:0]  pc_branch_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] data2_in,
  input  logic [31:0] dst_in,
  output logic        stall,
  output logic        pc_src,
  output logic [6:0]  pc_target,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic [31:0] wb_read_data,
  output logic [31:0] wb_alu_result,
`ifdef MEM_ALIGN_CHECK_EN
  output logic [4:0]  wb_dst,
  output logic        addr_err
`else
  output logic [4:0]  wb_dst
`endif
);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CNT_W-1:0]    w_count_nxt;
  logic                w_stall;
  logic                w_complete;
  logic                w_start;
  logic                w_is_mem;
  logic                w_aligned;
  logic                w_ram_we;
  logic [ADDR_W-1:0]   w_addr;
  logic [31:0]         w_ram_rdata;
  logic [31:0]         w_rd_next;

  logic                r_wb_reg_write;
  logic                r_wb_mem_to_reg;
  logic [31:0]         r_wb_read_data;
  logic [31:0]         r_wb_alu_result;
  logic [WB_DST_W-1:0] r_wb_dst;

  assign w_is_mem = mem_read_in | mem_write_in;
  assign w_addr   = alu_result_in[ADDR_W+1:2];

`ifdef MEM_ALIGN_CHECK_EN
  logic r_addr_err;
  logic w_unused;
  assign w_aligned = (alu_result_in[1:0] == 2'b00);
  assign w_unused  = ^{alu_result_in[31:ADDR_W+2], dst_in[31:WB_DST_W]};
  assign addr_err  = r_addr_err;
`else
  logic w_unused;
  assign w_aligned = 1'b1;
  assign w_unused  = ^{alu_result_in[31:ADDR_W+2], alu_result_in[1:0], dst_in[31:WB_DST_W]};
`endif

  // Latency 1 completes every cycle; otherwise IDLE -> ACCESS -> IDLE with a down-counter.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_stall     = 1'b0;
    w_complete  = 1'b0;
    w_start     = 1'b0;
    if (MEM_LATENCY == 1) begin
      w_complete = 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_is_mem) begin
            w_stall     = 1'b1;
            w_start     = 1'b1;
            w_state_nxt = ACCESS;
            w_count_nxt = CNT_W'(MEM_LATENCY - 2);
          end else begin
            w_complete = 1'b1;
          end
        end
        ACCESS: begin
          if (r_count != '0) begin
            w_stall     = 1'b1;
            w_count_nxt = r_count - 1'b1;
          end else begin
            w_complete  = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Reset gates the write so a store pending across an asserted reset never lands.
  assign w_ram_we  = w_complete & mem_write_in & w_aligned & ~reset;
  assign w_rd_next = (mem_read_in & w_aligned) ? w_ram_rdata : 32'h0;

  data_ram #(
    .ADDR_W (ADDR_W)
  ) u_data_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_addr  (w_addr),
    .i_wdata (data2_in),
    .o_rdata (w_ram_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_reg_write  <= 1'b0;
      r_wb_mem_to_reg <= 1'b0;
      r_wb_read_data  <= 32'h0;
      r_wb_alu_result <= 32'h0;
      r_wb_dst        <= '0;
    end else if (w_complete) begin
      r_wb_reg_write  <= reg_write_in;
      r_wb_mem_to_reg <= mem_to_reg_in;
      r_wb_read_data  <= w_rd_next;
      r_wb_alu_result <= alu_result_in;
      r_wb_dst        <= dst_in[WB_DST_W-1:0];
    end else if (w_start) begin
      r_wb_reg_write  <= 1'b0;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr_err <= 1'b0;
    end else if (w_complete && w_is_mem && !w_aligned) begin
      r_addr_err <= 1'b1;
    end
  end
`endif

  assign stall         = w_stall & ~reset;
  assign pc_src        = branch_in & zero_in & (r_state == IDLE);
  assign pc_target     = pc_branch_in;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_mem_to_reg = r_wb_mem_to_reg;
  assign wb_read_data  = r_wb_read_data;
  assign wb_alu_result = r_wb_alu_result;
  assign wb_dst        = r_wb_dst;

endmodule
